// File: rtl/xup_clk_period_meter.sv
// xup_clk_period_meter: measures the period of async sig_in in clkin cycles, with lock and timeout flags.
// Define XUP_CLK_METER_DUTY_EN to also report the high time of the last measured period.
module xup_clk_period_meter #(
   parameter int WIDTH       = 32,
   parameter int TIMEOUT     = 1000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clkin,
   input  logic             resetn,
   input  logic             sig_in,
   input  logic             enable,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout,
   output logic [WIDTH-1:0] high_time
);
   localparam logic [1:0] IDLE = 2'd0, WAIT_EDGE = 2'd1, MEASURE = 2'd2;
   localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev, s, rise, last_valid;
   logic [1:0]             state;
   logic [WIDTH-1:0]       cnt, last;
   assign s    = sync[SYNC_STAGES-1];
   assign rise = s & ~prev;
   always_ff @(posedge clkin or negedge resetn)
      if (!resetn) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sig_in};
         prev <= s;
      end
   // a rise takes priority over a coincident timeout so that period == TIMEOUT still measures
   always_ff @(posedge clkin or negedge resetn)
      if (!resetn) begin
         state        <= IDLE;
         cnt          <= '0;
         last         <= '0;
         last_valid   <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!enable) begin
            state      <= IDLE;
            cnt        <= '0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            last_valid <= 1'b0;
         end else if (state == IDLE) begin
            state <= WAIT_EDGE;
            cnt   <= '0;
         end else if (rise) begin
            state <= MEASURE;
            cnt   <= WIDTH'(1);
            if (state == MEASURE) begin
               period       <= cnt;
               period_valid <= 1'b1;
               last         <= cnt;
               locked       <= (cnt == last) && last_valid;
               last_valid   <= 1'b1;
               timeout      <= 1'b0;
            end
         end else if (cnt == TMO) begin
            state      <= WAIT_EDGE;
            cnt        <= '0;
            timeout    <= 1'b1;
            locked     <= 1'b0;
            last_valid <= 1'b0;
         end else begin
            cnt <= cnt + WIDTH'(1);
         end
      end
`ifdef XUP_CLK_METER_DUTY_EN
   logic [WIDTH-1:0] hcnt;
   always_ff @(posedge clkin or negedge resetn)
      if (!resetn) begin
         hcnt      <= '0;
         high_time <= '0;
      end else begin
         hcnt <= rise ? WIDTH'(s) : hcnt + WIDTH'(s);
         if (enable && state == MEASURE && rise) high_time <= hcnt;
      end
`else
   assign high_time = '0;
`endif
endmodule

// File: tb/tb_xup_clk_period_meter.sv
// tb_xup_clk_period_meter: self-checking bench; expected pulses are derived from the driven edge times.
// Honours XUP_CLK_METER_DUTY_EN for the high_time expectations.
module tb_xup_clk_period_meter;
   localparam int TMO  = 100;
   localparam int SYNC = 2;
`ifdef XUP_CLK_METER_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif
   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] per;
      logic        lk;
      logic        to;
      logic [31:0] ht;
   } pulse_t;
   typedef struct {
      int c;
      int hi;
   } rise_t;
   logic        clkin = 1'b0, resetn = 1'b0, sig_in = 1'b0, enable = 1'b0;
   logic [31:0] period, high_time;
   logic        period_valid, locked, timeout;
   int          cyc = 0, checks = 0, errors = 0;
   pulse_t      obs_q[$], exp_q[$];
   rise_t       edge_q[$];

   xup_clk_period_meter #(.WIDTH(32), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
      .clkin(clkin), .resetn(resetn), .sig_in(sig_in), .enable(enable),
      .period(period), .period_valid(period_valid), .locked(locked),
      .timeout(timeout), .high_time(high_time)
   );

   always #5 clkin = ~clkin;
   always @(posedge clkin) cyc <= cyc + 1;
   always @(negedge clkin)
      if (period_valid === 1'b1) obs_q.push_back({32'(cyc), period, locked, timeout, high_time});

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic hold_low(input int n);
      repeat (n) @(negedge clkin);
   endtask

   // each period: hi cycles high then lo cycles low; the edge is sampled at the next posedge
   task automatic wave(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clkin);
         edge_q.push_back('{cyc + 1, hi});
         sig_in = 1'b1;
         repeat (hi) @(negedge clkin);
         sig_in = 1'b0;
         repeat (lo - 1) @(negedge clkin);
      end
   endtask

   task automatic restart();
      @(negedge clkin);
      enable = 1'b0;
      repeat (2) @(negedge clkin);
      enable = 1'b1;
      repeat (3) @(negedge clkin);
      edge_q.delete();
      obs_q.delete();
   endtask

   // a measurement needs two edges in one chain; a gap above TMO breaks the chain
   function automatic void build_expected();
      int last_p = 0;
      bit have_p = 1'b0;
      exp_q.delete();
      for (int i = 1; i < edge_q.size(); i++) begin
         int gap = edge_q[i].c - edge_q[i-1].c;
         if (gap > TMO) begin
            have_p = 1'b0;
         end else begin
            exp_q.push_back({32'(edge_q[i].c + SYNC), 32'(gap), have_p && gap == last_p, 1'b0,
                             DUTY ? 32'(edge_q[i-1].hi) : 32'd0});
            have_p = 1'b1;
            last_p = gap;
         end
      end
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clkin);
      checks += 5;
      if (period !== 32'd0) begin errors++; $display("FAIL rst_period got %0d want 0", period); end
      if (period_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", period_valid); end
      if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout); end
      if (high_time !== 32'd0) begin errors++; $display("FAIL rst_high got %0d want 0", high_time); end
      resetn = 1'b1;
   endtask

   task automatic test_lock();
      restart();
      wave(5, 5, 4);
      wave(7, 13, 3);
      hold_low(5);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL lock_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL lock_pulse%0d got cyc=%0d per=%0d lk=%b to=%b ht=%0d want cyc=%0d per=%0d lk=%b to=%b ht=%0d", i,
                     obs_q[i].cyc, obs_q[i].per, obs_q[i].lk, obs_q[i].to, obs_q[i].ht,
                     exp_q[i].cyc, exp_q[i].per, exp_q[i].lk, exp_q[i].to, exp_q[i].ht);
         end
      end
   endtask

   task automatic test_timeout();
      int l = obs_q.size() > 0 ? int'(obs_q[$].cyc) : 0;
      int n = 0;
      while (timeout !== 1'b1 && n < 300) begin
         @(negedge clkin);
         n++;
      end
      checks += 3;
      if (timeout !== 1'b1 || cyc != l + TMO) begin
         errors++;
         $display("FAIL to_cycle got timeout=%b at cyc %0d want 1 at cyc %0d", timeout, cyc, l + TMO);
      end
      if (locked !== 1'b0) begin errors++; $display("FAIL to_locked got %b want 0", locked); end
      if (period !== 32'd20) begin errors++; $display("FAIL to_period got %0d want 20", period); end
      edge_q.delete();
      obs_q.delete();
      wave(5, 5, 1);
      checks++;
      if (timeout !== 1'b1 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL to_sticky got timeout=%b pulses=%0d want 1 and 0", timeout, obs_q.size());
      end
      wave(5, 5, 2);
      hold_low(5);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL to_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL to_pulse%0d got cyc=%0d per=%0d lk=%b to=%b ht=%0d want cyc=%0d per=%0d lk=%b to=%b ht=%0d", i,
                     obs_q[i].cyc, obs_q[i].per, obs_q[i].lk, obs_q[i].to, obs_q[i].ht,
                     exp_q[i].cyc, exp_q[i].per, exp_q[i].lk, exp_q[i].to, exp_q[i].ht);
         end
      end
   endtask

   task automatic test_disable();
      restart();
      wave(5, 5, 3);
      hold_low(2);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL dis_prelock got %b want 1", locked); end
      enable = 1'b0;
      @(negedge clkin);
      checks += 4;
      if (locked !== 1'b0) begin errors++; $display("FAIL dis_locked got %b want 0", locked); end
      if (period !== 32'd10) begin errors++; $display("FAIL dis_period got %0d want 10", period); end
      if (period_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %b want 0", period_valid); end
      if (high_time !== (DUTY ? 32'd5 : 32'd0)) begin errors++; $display("FAIL dis_high got %0d want %0d", high_time, DUTY ? 5 : 0); end
      enable = 1'b1;
      hold_low(110);
      checks++;
      if (timeout !== 1'b1) begin errors++; $display("FAIL dis_pretimeout got %b want 1", timeout); end
      enable = 1'b0;
      @(negedge clkin);
      checks += 2;
      if (timeout !== 1'b0) begin errors++; $display("FAIL dis_timeout got %b want 0", timeout); end
      if (period !== 32'd10) begin errors++; $display("FAIL dis_period2 got %0d want 10", period); end
      enable = 1'b1;
      hold_low(3);
      edge_q.delete();
      obs_q.delete();
      wave(5, 5, 1);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL dis_first got %0d pulses want 0", obs_q.size()); end
      wave(5, 5, 2);
      hold_low(5);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL dis_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL dis_pulse%0d got cyc=%0d per=%0d lk=%b to=%b ht=%0d want cyc=%0d per=%0d lk=%b to=%b ht=%0d", i,
                     obs_q[i].cyc, obs_q[i].per, obs_q[i].lk, obs_q[i].to, obs_q[i].ht,
                     exp_q[i].cyc, exp_q[i].per, exp_q[i].lk, exp_q[i].to, exp_q[i].ht);
         end
      end
   endtask

   task automatic test_async_reset();
      restart();
      wave(5, 5, 3);
      hold_low(2);
      #2 resetn = 1'b0;
      #1;
      checks += 5;
      if (period !== 32'd0) begin errors++; $display("FAIL ar_period got %0d want 0", period); end
      if (period_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", period_valid); end
      if (locked !== 1'b0) begin errors++; $display("FAIL ar_locked got %b want 0", locked); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL ar_timeout got %b want 0", timeout); end
      if (high_time !== 32'd0) begin errors++; $display("FAIL ar_high got %0d want 0", high_time); end
      @(negedge clkin);
      resetn = 1'b1;
      hold_low(3);
      edge_q.delete();
      obs_q.delete();
      wave(5, 5, 3);
      hold_low(5);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ar_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ar_pulse%0d got cyc=%0d per=%0d lk=%b to=%b ht=%0d want cyc=%0d per=%0d lk=%b to=%b ht=%0d", i,
                     obs_q[i].cyc, obs_q[i].per, obs_q[i].lk, obs_q[i].to, obs_q[i].ht,
                     exp_q[i].cyc, exp_q[i].per, exp_q[i].lk, exp_q[i].to, exp_q[i].ht);
         end
      end
   endtask

   task automatic test_boundary();
      restart();
      wave(50, 50, 3);
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL bnd_no_timeout got %b want 0", timeout); end
      wave(50, 51, 2);
      hold_low(5);
      checks++;
      if (timeout !== 1'b1) begin errors++; $display("FAIL bnd_timeout got %b want 1", timeout); end
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bnd_pulse%0d got cyc=%0d per=%0d lk=%b to=%b ht=%0d want cyc=%0d per=%0d lk=%b to=%b ht=%0d", i,
                     obs_q[i].cyc, obs_q[i].per, obs_q[i].lk, obs_q[i].to, obs_q[i].ht,
                     exp_q[i].cyc, exp_q[i].per, exp_q[i].lk, exp_q[i].to, exp_q[i].ht);
         end
      end
   endtask

   task automatic test_random();
      restart();
      for (int seg = 0; seg < 8; seg++) begin
         int hi = $urandom_range(1, 30);
         int lo = $urandom_range(1, 30);
         if ($urandom_range(0, 3) == 0) lo = $urandom_range(90, 130);
         wave(hi, lo, $urandom_range(1, 4));
      end
      hold_low(5);
      build_expected();
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd_pulse%0d got cyc=%0d per=%0d lk=%b to=%b ht=%0d want cyc=%0d per=%0d lk=%b to=%b ht=%0d", i,
                     obs_q[i].cyc, obs_q[i].per, obs_q[i].lk, obs_q[i].to, obs_q[i].ht,
                     exp_q[i].cyc, exp_q[i].per, exp_q[i].lk, exp_q[i].to, exp_q[i].ht);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_timeout();
      test_disable();
      test_async_reset();
      test_boundary();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
